// File: rtl/lagunar_video_fetch.sv
// lagunar_video_fetch: raster timing, 1bpp bitmap fetch from video RAM and pixel serialiser.
// Optional cocktail flip (180-degree rotation) when VIDEO_FLIP_EN is defined.
module lagunar_video_fetch #(
   parameter int H_TOTAL  = 320,
   parameter int V_TOTAL  = 262,
   parameter int V_ACTIVE = 224,
   parameter int IRQ_MID  = 96
) (
   input  logic        Clock,
   input  logic        Reset_n,
   input  logic        Pix_ce,
   input  logic        Flip,
   output logic        Vid_Req,
   output logic [12:0] Vid_Addr,
   input  logic [7:0]  Ram_out,
   output logic        Pixel,
   output logic        Video_Act,
   output logic        HSync,
   output logic        VSync,
   output logic        Irq_Mid,
   output logic        Irq_End
);

   localparam logic [8:0] H_LAST = 9'(H_TOTAL - 1);
   localparam logic [8:0] V_LAST = 9'(V_TOTAL - 1);
   localparam logic [8:0] V_ACT  = 9'(V_ACTIVE);
   localparam logic [8:0] V_MID  = 9'(IRQ_MID);

   logic [8:0] hcount_q, hcount_d;
   logic [8:0] vcount_q, vcount_d;
   logic [7:0] shift_q, shift_d;
   logic [7:0] hold_q, hold_d;
   logic       req_dly_q, req_dly_d;
   logic       vid_req_q, vid_req_d;
   logic       pixel_q, pixel_d;
   logic       video_act_q, video_act_d;
   logic       hsync_q, hsync_d;
   logic       vsync_q, vsync_d;
   logic       irq_mid_q, irq_mid_d;
   logic       irq_end_q, irq_end_d;
   logic       flip_c;
   logic       act_c, act_n, fetch_n, load_c;
   logic [7:0] row;
   logic [4:0] col;

`ifdef VIDEO_FLIP_EN
   logic flip_q, flip_d;

   // Flip only changes at line start so a line is never half-rotated
   always_comb flip_d = (hcount_q == 9'd0) ? Flip : flip_q;

   always_ff @(posedge Clock) begin
      if (!Reset_n) flip_q <= 1'b0;
      else          flip_q <= flip_d;
   end

   assign flip_c = flip_q;
`else
   logic unused_flip;
   assign unused_flip = Flip;
   assign flip_c      = 1'b0;
`endif

   always_comb begin
      hcount_d = hcount_q;
      vcount_d = vcount_q;
      if (Pix_ce) begin
         if (hcount_q == H_LAST) begin
            hcount_d = '0;
            vcount_d = (vcount_q == V_LAST) ? 9'd0 : vcount_q + 9'd1;
         end else begin
            hcount_d = hcount_q + 9'd1;
         end
      end
   end

   always_comb begin
      act_c = (vcount_q < V_ACT) && (hcount_q >= 9'd8)
              && (hcount_q <= 9'd263);
      act_n = (vcount_d < V_ACT) && (hcount_d >= 9'd8)
              && (hcount_d <= 9'd263);
      fetch_n = (vcount_d < V_ACT) && (hcount_d < 9'd256)
                && (hcount_d[2:0] == 3'd6);
      load_c = Pix_ce && (vcount_q < V_ACT) && (hcount_q < 9'd256)
               && (hcount_q[2:0] == 3'd7);
   end

   always_comb begin
      shift_d = shift_q;
      if (load_c) begin
         shift_d = hold_q;
      end else if (Pix_ce && act_c) begin
         shift_d = flip_c ? {shift_q[6:0], 1'b0} : {1'b0, shift_q[7:1]};
      end
   end

   // Outputs are registered from the next position so they line up with it
   always_comb begin
      video_act_d = video_act_q;
      pixel_d     = pixel_q;
      hsync_d     = hsync_q;
      vsync_d     = vsync_q;
      if (Pix_ce) begin
         video_act_d = act_n;
         pixel_d     = act_n & (flip_c ? shift_d[7] : shift_d[0]);
         hsync_d     = (hcount_d >= 9'd272) && (hcount_d <= 9'd303);
         vsync_d     = (vcount_d >= 9'd236) && (vcount_d <= 9'd239);
      end
      vid_req_d = Pix_ce && fetch_n;
      irq_mid_d = Pix_ce && (hcount_d == 9'd0) && (vcount_d == V_MID);
      irq_end_d = Pix_ce && (hcount_d == 9'd0) && (vcount_d == V_ACT);
      req_dly_d = vid_req_q;
      hold_d    = req_dly_q ? Ram_out : hold_q;
   end

   always_comb begin
      row = vcount_q[7:0];
      col = hcount_q[7:3];
      if (flip_c) begin
         row = 8'd223 - vcount_q[7:0];
         col = 5'd31 - hcount_q[7:3];
      end
   end

   assign Vid_Addr = 13'h0400 + {row, col};

   always_ff @(posedge Clock) begin
      if (!Reset_n) begin
         hcount_q    <= '0;
         vcount_q    <= '0;
         shift_q     <= '0;
         hold_q      <= '0;
         req_dly_q   <= 1'b0;
         vid_req_q   <= 1'b0;
         pixel_q     <= 1'b0;
         video_act_q <= 1'b0;
         hsync_q     <= 1'b0;
         vsync_q     <= 1'b0;
         irq_mid_q   <= 1'b0;
         irq_end_q   <= 1'b0;
      end else begin
         hcount_q    <= hcount_d;
         vcount_q    <= vcount_d;
         shift_q     <= shift_d;
         hold_q      <= hold_d;
         req_dly_q   <= req_dly_d;
         vid_req_q   <= vid_req_d;
         pixel_q     <= pixel_d;
         video_act_q <= video_act_d;
         hsync_q     <= hsync_d;
         vsync_q     <= vsync_d;
         irq_mid_q   <= irq_mid_d;
         irq_end_q   <= irq_end_d;
      end
   end

   assign Vid_Req   = vid_req_q;
   assign Pixel     = pixel_q;
   assign Video_Act = video_act_q;
   assign HSync     = hsync_q;
   assign VSync     = vsync_q;
   assign Irq_Mid   = irq_mid_q;
   assign Irq_End   = irq_end_q;

endmodule
